// File: rtl/alu4_seq_ctrl.sv
// Sequencing front end for the 4-bit signed ALU: accepts commands over valid/ready,
// holds a small register file, drives the ALU for one cycle and writes back result and flags.
module alu4_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ldi,
  input  logic [2:0]       cmd_op,
  input  logic [IW-1:0]    cmd_rd,
  input  logic [IW-1:0]    cmd_rs1,
  input  logic [IW-1:0]    cmd_rs2,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [3:0]       flags,
  output logic             done,
  input  logic [IW-1:0]    rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [IW-1:0]    rd_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ctrl_q;
  logic [WIDTH-1:0] wb_val_q;
  logic [3:0]       wb_flags_q;
  logic [3:0]       flags_q;
  logic             done_q;
  logic             ready_q;

  logic [3:0]       exec_flags_d;
  logic [3:0]       ldi_flags_d;

  // Only add/sub own C and V; every other op keeps the previous carry/overflow.
  always_comb begin
    exec_flags_d = {alu_n, alu_z, alu_c, alu_v};
    if (ctrl_q[2:1] != 2'b00) begin
      exec_flags_d[1:0] = flags_q[1:0];
    end else begin
      exec_flags_d[1:0] = {alu_c, alu_v};
    end
  end

  assign ldi_flags_d = {cmd_imm[WIDTH-1], (cmd_imm == {WIDTH{1'b0}}), flags_q[1:0]};

  // Command FSM, operand/result capture, register file and flags writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      flags_q    <= 4'b0100;
      wb_flags_q <= 4'b0000;
      wb_val_q   <= {WIDTH{1'b0}};
      rd_q       <= {IW{1'b0}};
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      ctrl_q     <= 3'b000;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (cmd_valid) begin
            rd_q    <= cmd_rd;
            ready_q <= 1'b0;
            if (cmd_ldi) begin
              wb_val_q   <= cmd_imm;
              wb_flags_q <= ldi_flags_d;
              done_q     <= 1'b1;
              state_q    <= WB;
            end else begin
              a_q     <= regs_q[cmd_rs1];
              b_q     <= regs_q[cmd_rs2];
              ctrl_q  <= cmd_op;
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          wb_val_q   <= alu_result;
          wb_flags_q <= exec_flags_d;
          done_q     <= 1'b1;
          state_q    <= WB;
        end
        WB: begin
          regs_q[rd_q] <= wb_val_q;
          flags_q      <= wb_flags_q;
          done_q       <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign flags     = flags_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = ctrl_q;
  assign rd_data   = regs_q[rd_sel];

endmodule
